// File: rtl/wb_stage.sv
// Write-back stage: result select, 31-entry register file with write-through
// bypass to the decode read ports, and a retired-instruction counter.
module wb_stage #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidW,
    input  logic             RegWriteW,
    input  logic [2:0]       WriteBackW,
    input  logic [31:0]      ALUResultW,
    input  logic [31:0]      ReadDataW,
    input  logic [31:0]      PCTargetW,
    input  logic [31:0]      ImmExtW,
    input  logic [31:0]      PCPlus4W,
    input  logic [4:0]       RdW,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    output logic [31:0]      RD1D,
    output logic [31:0]      RD2D,
    output logic [31:0]      ResultW,
    output logic [CNT_W-1:0] InstRetW
);

    logic [31:0]      regs_q [1:31];
    logic [CNT_W-1:0] inst_q;
    logic [CNT_W-1:0] inst_d;
    logic             commit;

    assign commit = ValidW & RegWriteW & (RdW != 5'd0);

    always_comb begin
        ResultW = ALUResultW;
        unique case (WriteBackW)
            3'b001:  ResultW = ReadDataW;
            3'b010:  ResultW = PCPlus4W;
            3'b011:  ResultW = ImmExtW;
            3'b100:  ResultW = PCTargetW;
            default: ResultW = ALUResultW;
        endcase
    end

    // x0 is never stored; a same-cycle commit to the read index wins over the array.
    always_comb begin
        RD1D = 32'd0;
        if (Rs1D != 5'd0) begin
            if (commit && (RdW == Rs1D)) begin
                RD1D = ResultW;
            end else begin
                RD1D = regs_q[Rs1D];
            end
        end
    end

    always_comb begin
        RD2D = 32'd0;
        if (Rs2D != 5'd0) begin
            if (commit && (RdW == Rs2D)) begin
                RD2D = ResultW;
            end else begin
                RD2D = regs_q[Rs2D];
            end
        end
    end

    always_comb begin
        inst_d = inst_q;
        if (ValidW) begin
            inst_d = inst_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            inst_q <= '0;
        end else begin
            if (commit) begin
                regs_q[RdW] <= ResultW;
            end
            inst_q <= inst_d;
        end
    end

    assign InstRetW = inst_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: mux table, directed corner sequences and
// randomized traffic against an architectural register-file/counter model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidW, RegWriteW;
    logic [2:0]  WriteBackW;
    logic [31:0] ALUResultW, ReadDataW, PCTargetW, ImmExtW, PCPlus4W;
    logic [4:0]  RdW, Rs1D, Rs2D;
    logic [31:0] RD1D, RD2D, ResultW;
    logic [63:0] InstRetW;
    logic [31:0] rd1_s, rd2_s, res_s;
    logic [3:0]  inst_s;

    always #5 clk = ~clk;

    wb_stage #(.CNT_W(64)) dut (
        .clk(clk), .reset(reset), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .WriteBackW(WriteBackW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCTargetW(PCTargetW), .ImmExtW(ImmExtW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
        .InstRetW(InstRetW)
    );

    // Narrow-counter copy sharing the same stimulus, used for the wrap check.
    wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .WriteBackW(WriteBackW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCTargetW(PCTargetW), .ImmExtW(ImmExtW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(rd1_s), .RD2D(rd2_s), .ResultW(res_s),
        .InstRetW(inst_s)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] exp;
    } mux_vec_t;

    mux_vec_t    mv [8];
    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result();
        logic [31:0] cand [8];
        cand = '{ALUResultW, ReadDataW, PCPlus4W, ImmExtW, PCTargetW,
                 ALUResultW, ALUResultW, ALUResultW};
        return cand[WriteBackW];
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (ValidW && RegWriteW && RdW != 5'd0 && RdW == rs) return ref_result();
        return m_regs[rs];
    endfunction

    task automatic check_comb();
        chk("result", ResultW, ref_result());
        chk("rd1", RD1D, ref_read(Rs1D));
        chk("rd2", RD2D, ref_read(Rs2D));
    endtask

    // Advance one rising edge, retire into the model, then check the counters.
    task automatic clock_edge();
        logic        commit;
        logic [31:0] r;
        commit = ValidW && RegWriteW && (RdW != 5'd0);
        r      = ref_result();
        @(posedge clk);
        if (reset) begin
            if (commit) m_regs[RdW] = r;
            if (ValidW) m_cnt = m_cnt + 64'd1;
        end
        #1;
        chk("instret", InstRetW, m_cnt);
        chk("instret4", {60'd0, inst_s}, {60'd0, m_cnt[3:0]});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 64'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_instret", InstRetW, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        ValidW = 0; RegWriteW = 0; WriteBackW = 3'd0; RdW = 5'd0;
        Rs1D = 5'd0; Rs2D = 5'd0;
    endtask

    initial begin
        mv[0] = '{3'd0, 32'h11}; mv[1] = '{3'd1, 32'h22};
        mv[2] = '{3'd2, 32'h33}; mv[3] = '{3'd3, 32'h44};
        mv[4] = '{3'd4, 32'h55}; mv[5] = '{3'd5, 32'h11};
        mv[6] = '{3'd6, 32'h11}; mv[7] = '{3'd7, 32'h11};

        idle_inputs();
        ALUResultW = 32'h11; ReadDataW = 32'h22; PCPlus4W = 32'h33;
        ImmExtW = 32'h44; PCTargetW = 32'h55;
        reset = 1'b0;
        #3;
        Rs1D = 5'd5;
        #1;
        chk("reset_x5", RD1D, 32'd0);
        chk("reset_cnt", InstRetW, 64'd0);
        do_reset();

        // Result mux sweep
        for (int i = 0; i < 8; i++) begin
            WriteBackW = mv[i].sel;
            #1;
            chk($sformatf("mux_sel%0d", i), ResultW, mv[i].exp);
        end

        // Write then read back from the array
        @(posedge clk); #1;
        ValidW = 1; RegWriteW = 1; WriteBackW = 3'd0; RdW = 5'd5;
        ALUResultW = 32'hDEADBEEF; Rs1D = 5'd0; Rs2D = 5'd0;
        #1; check_comb();
        clock_edge();
        RegWriteW = 0; Rs1D = 5'd5; Rs2D = 5'd0;
        #1;
        chk("wr_rd1", RD1D, 32'hDEADBEEF);
        chk("wr_rd2_x0", RD2D, 32'd0);
        clock_edge();

        // Same-cycle bypass on both ports
        RegWriteW = 1; RdW = 5'd7; ALUResultW = 32'h1234; Rs1D = 5'd7; Rs2D = 5'd7;
        #1;
        chk("byp_rd1", RD1D, 32'h1234);
        chk("byp_rd2", RD2D, 32'h1234);
        clock_edge();

        // Write to x0 is dropped but still retires
        RdW = 5'd0; ALUResultW = 32'hFFFFFFFF; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        chk("x0_rd1", RD1D, 32'd0);
        clock_edge();
        chk("x0_cnt", InstRetW, 64'd4);

        // Bubble with RegWriteW set: no write, no count
        ValidW = 0; RegWriteW = 1; RdW = 5'd3; ALUResultW = 32'hCAFE; Rs1D = 5'd3;
        #1;
        chk("bub_nobyp", RD1D, 32'd0);
        clock_edge();
        chk("bub_x3", RD1D, 32'd0);
        chk("bub_cnt", InstRetW, 64'd4);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            ValidW     = ($urandom_range(0, 3) != 0);
            RegWriteW  = ($urandom_range(0, 3) != 0);
            WriteBackW = 3'($urandom_range(0, 7));
            ALUResultW = $urandom; ReadDataW = $urandom; PCTargetW = $urandom;
            ImmExtW    = $urandom; PCPlus4W  = $urandom;
            RdW        = 5'($urandom_range(0, 31));
            Rs1D       = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
            Rs2D       = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
            #1; check_comb();
            clock_edge();
        end

        // Counter wrap on the 4-bit instance
        idle_inputs();
        do_reset();
        ValidW = 1;
        for (int n = 0; n < 17; n++) clock_edge();
        chk("wrap_cnt4", {60'd0, inst_s}, 64'd1);
        chk("wrap_cnt64", InstRetW, 64'd17);

        // Reset mid-run
        idle_inputs();
        do_reset();
        ValidW = 1; RegWriteW = 1; WriteBackW = 3'd0; RdW = 5'd9; ALUResultW = 32'hA5A5A5A5;
        clock_edge();
        RegWriteW = 0;
        for (int n = 0; n < 9; n++) clock_edge();
        ValidW = 0; Rs1D = 5'd9;
        #1;
        chk("mid_x9", RD1D, 32'hA5A5A5A5);
        chk("mid_cnt10", InstRetW, 64'd10);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_x9", RD1D, 32'd0);
        chk("mid_rst_cnt", InstRetW, 64'd0);
        ValidW = 1; RegWriteW = 1; RdW = 5'd9; ALUResultW = 32'h77; Rs2D = 5'd9;
        #1;
        chk("rst_bypass", RD2D, 32'h77);
        clock_edge();
        ValidW = 0;
        #1;
        chk("rst_discard", RD2D, 32'd0);
        chk("rst_nocount", InstRetW, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ValidW = 1; RegWriteW = 1; RdW = 5'd9; ALUResultW = 32'h99;
        clock_edge();
        ValidW = 0; RegWriteW = 0;
        #1;
        chk("post_cnt1", InstRetW, 64'd1);
        chk("post_x9", RD1D, 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
